// File: rtl/wm_pkg.sv
// Shared types and helpers for the pipelined watermark insertion datapath.
package wm_pkg;

  typedef enum logic [1:0] {
    WM_NONE = 2'b00,
    WM_C    = 2'b01,
    WM_B    = 2'b10,
    WM_RSVD = 2'b11
  } wm_sym_e;

  localparam int unsigned COEF_FRAC_DEF = 8;
  localparam int unsigned COEF_W_DEF    = COEF_FRAC_DEF + 1;
  localparam logic [COEF_W_DEF-1:0] COEF_ONE  = 9'd256;
  localparam logic [COEF_W_DEF-1:0] COEF_ZERO = 9'd0;

  // Widest statistics counter the increment helper supports.
  localparam int unsigned CNT_MAX_W = 32;

  // Per-stage control sideband travelling alongside the pixel data.
  typedef struct packed {
    logic    valid;
    logic    last;
    wm_sym_e mode;
  } beat_ctl_t;

  // Saturating increment: sticks at max_val once reached.
  function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] cnt,
                                                   input logic [CNT_MAX_W-1:0] max_val);
    return (cnt >= max_val) ? max_val : cnt + CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/wm_insert_pipe_fx_mul.sv
// Registered unsigned pixel x Q1.FRAC_W coefficient multiply, fraction bits dropped.
module wm_fx_mul #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned COEF_W = FRAC_W + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ce,
  input  logic [PIX_W-1:0]                  pix,
  input  logic [COEF_W-1:0]                 coef,
  output logic [PIX_W+COEF_W-FRAC_W-1:0]    prod
);

  localparam int unsigned FULL_W = PIX_W + COEF_W;
  localparam int unsigned OUT_W  = FULL_W - FRAC_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
    end else if (ce) begin
      prod <= OUT_W'((FULL_W'(pix) * FULL_W'(coef)) >> FRAC_W);
    end
  end

endmodule

// File: rtl/wm_insert_pipe.sv
// Three-stage streaming watermark inserter: neighbour average, weighted products,
// saturating/wrapping sum, with last-beat sideband and emitted-beat statistics.
module wm_insert_pipe
  import wm_pkg::*;
#(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned COEF_W = FRAC_W + 1,
  parameter int unsigned SAT    = 1,
  parameter int unsigned CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [COEF_W-1:0] coef_a,
  input  logic [COEF_W-1:0] coef_b,
  input  logic [COEF_W-1:0] coef_c,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  data1,
  input  logic [PIX_W-1:0]  data2,
  input  logic [PIX_W-1:0]  data3,
  input  logic [PIX_W-1:0]  data4,
  input  logic [1:0]        wm_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  wm_im_data,
  output logic              out_last,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  wm_count,
  output logic [CNT_W-1:0]  sat_count
);

  localparam int unsigned M_W   = PIX_W + COEF_W - FRAC_W;
  localparam int unsigned SUM_W = M_W + 1;
  localparam logic [SUM_W-1:0] PIX_MAX  = SUM_W'({PIX_W{1'b1}});
  localparam logic [CNT_W-1:0] CNT_ONES = '1;

  logic adv;
  logic accept;
  logic ready_en;
  logic out_hs;

  // Single global advance: the whole pipe moves unless the output is stalled.
  assign adv    = !out_valid || out_ready;
  assign in_ready = ready_en && adv;
  assign accept = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // Holds in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Stage 1 combinational: neighbour averaging, effective mode, host weight select.
  logic [PIX_W:0]    sum24_c;
  logic [PIX_W:0]    sum3a_c;
  logic [PIX_W-1:0]  avg1_c;
  logic [PIX_W-1:0]  avg2_c;
  wm_sym_e           mode_c;
  logic [COEF_W-1:0] coef_h_c;

  always_comb begin
    sum24_c  = {1'b0, data2} + {1'b0, data4};
    avg1_c   = PIX_W'(sum24_c >> 1);
    sum3a_c  = {1'b0, data3} + {1'b0, avg1_c};
    avg2_c   = PIX_W'(sum3a_c >> 1);
    mode_c   = enable ? wm_sym_e'(wm_data) : WM_NONE;
    coef_h_c = '0;
    case (mode_c)
      WM_C:    coef_h_c = coef_c;
      WM_B:    coef_h_c = coef_b;
      default: coef_h_c = '0;
    endcase
  end

  beat_ctl_t         s1_ctl;
  logic [PIX_W-1:0]  s1_data1;
  logic [PIX_W-1:0]  s1_avg2;
  logic [COEF_W-1:0] s1_coef_a;
  logic [COEF_W-1:0] s1_coef_h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ctl    <= '0;
      s1_data1  <= '0;
      s1_avg2   <= '0;
      s1_coef_a <= '0;
      s1_coef_h <= '0;
    end else if (adv) begin
      s1_ctl    <= beat_ctl_t'{valid: accept, last: in_last, mode: mode_c};
      s1_data1  <= data1;
      s1_avg2   <= avg2_c;
      s1_coef_a <= coef_a;
      s1_coef_h <= coef_h_c;
    end
  end

  // Stage 2: both products registered inside the multipliers.
  logic [M_W-1:0]   m1;
  logic [M_W-1:0]   m2;
  beat_ctl_t        s2_ctl;
  logic [PIX_W-1:0] s2_data1;

  wm_fx_mul #(
    .PIX_W  (PIX_W),
    .FRAC_W (FRAC_W),
    .COEF_W (COEF_W)
  ) u_mul_host (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (adv),
    .pix   (s1_data1),
    .coef  (s1_coef_h),
    .prod  (m1)
  );

  wm_fx_mul #(
    .PIX_W  (PIX_W),
    .FRAC_W (FRAC_W),
    .COEF_W (COEF_W)
  ) u_mul_avg (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (adv),
    .pix   (s1_avg2),
    .coef  (s1_coef_a),
    .prod  (m2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_ctl   <= '0;
      s2_data1 <= '0;
    end else if (adv) begin
      s2_ctl   <= s1_ctl;
      s2_data1 <= s1_data1;
    end
  end

  // Stage 3 combinational: sum, overflow, pass-through for non-watermark symbols.
  logic [SUM_W-1:0] sum_c;
  logic             ovf_c;
  logic             wm_c;
  logic [PIX_W-1:0] pix_c;

  always_comb begin
    sum_c = SUM_W'(m1) + SUM_W'(m2);
    ovf_c = 1'b0;
    wm_c  = 1'b0;
    pix_c = s2_data1;
    if (s2_ctl.mode == WM_C || s2_ctl.mode == WM_B) begin
      wm_c  = 1'b1;
      ovf_c = sum_c > PIX_MAX;
      if (SAT != 0 && ovf_c) begin
        pix_c = '1;
      end else begin
        pix_c = sum_c[PIX_W-1:0];
      end
    end
  end

  logic s3_wm;
  logic s3_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      wm_im_data <= '0;
      out_last   <= 1'b0;
      s3_wm      <= 1'b0;
      s3_ovf     <= 1'b0;
    end else if (adv) begin
      out_valid  <= s2_ctl.valid;
      wm_im_data <= pix_c;
      out_last   <= s2_ctl.last;
      s3_wm      <= wm_c;
      s3_ovf     <= ovf_c;
    end
  end

  // Statistics over emitted beats; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wm_count  <= '0;
      sat_count <= '0;
    end else if (cnt_clr) begin
      wm_count  <= '0;
      sat_count <= '0;
    end else if (out_hs) begin
      if (s3_wm) begin
        wm_count <= CNT_W'(sat_inc(CNT_MAX_W'(wm_count), CNT_MAX_W'(CNT_ONES)));
      end
      if (s3_ovf) begin
        sat_count <= CNT_W'(sat_inc(CNT_MAX_W'(sat_count), CNT_MAX_W'(CNT_ONES)));
      end
    end
  end

endmodule

// File: tb/tb_wm_insert_pipe.sv
// Bench for wm_insert_pipe: saturating and wrapping instances share one stimulus stream.
module tb_wm_insert_pipe;
  import wm_pkg::*;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned COEF_W = 9;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_FULL = 4'd15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic [COEF_W-1:0] coef_a = '0, coef_b = '0, coef_c = '0;
  logic in_valid = 1'b0;
  logic [PIX_W-1:0] data1 = '0, data2 = '0, data3 = '0, data4 = '0;
  logic [1:0] wm_data = '0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic cnt_clr = 1'b0;

  logic in_ready_s, in_ready_w, out_valid_s, out_valid_w, last_s, last_w;
  logic [PIX_W-1:0] data_s, data_w;
  logic [CNT_W-1:0] wmc_s, wmc_w, satc_s, satc_w;

  wm_insert_pipe #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .COEF_W(COEF_W), .SAT(1), .CNT_W(CNT_W)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(enable), .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
    .in_valid(in_valid), .in_ready(in_ready_s), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .wm_data(wm_data), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .wm_im_data(data_s), .out_last(last_s), .cnt_clr(cnt_clr),
    .wm_count(wmc_s), .sat_count(satc_s));

  wm_insert_pipe #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .COEF_W(COEF_W), .SAT(0), .CNT_W(CNT_W)) dut_w (
    .clk(clk), .rst_n(rst_n), .enable(enable), .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
    .in_valid(in_valid), .in_ready(in_ready_w), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .wm_data(wm_data), .in_last(in_last), .out_valid(out_valid_w),
    .out_ready(out_ready), .wm_im_data(data_w), .out_last(last_w), .cnt_clr(cnt_clr),
    .wm_count(wmc_w), .sat_count(satc_w));

  initial forever #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] wm;
    logic [7:0] d1, d2, d3, d4;
    logic [8:0] ca, cb, cc;
    logic       last;
    logic [7:0] es, ew;
    logic       eovf, ewm;
  } vec_t;

  typedef struct packed {
    logic [7:0] ds, dw;
    logic       last, ovf, wm;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];
  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] m_wm = '0, m_sat = '0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_ds, prev_dw;
  logic prev_last;
  logic rnd_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic vec_t mk(input logic en, input logic [1:0] wm, input int d1, input int d2,
                              input int d3, input int d4, input int ca, input int cb, input int cc,
                              input int es, input int ew, input logic eovf, input logic ewm);
    vec_t v;
    v.en = en; v.wm = wm;
    v.d1 = 8'(d1); v.d2 = 8'(d2); v.d3 = 8'(d3); v.d4 = 8'(d4);
    v.ca = 9'(ca); v.cb = 9'(cb); v.cc = 9'(cc);
    v.last = 1'b0;
    v.es = 8'(es); v.ew = 8'(ew); v.eovf = eovf; v.ewm = ewm;
    return v;
  endfunction

  // Reference arithmetic on plain integers.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int a1, a2, m1, m2, sum, mode;
    r = v;
    mode = v.en ? int'(v.wm) : 0;
    a1 = (int'(v.d2) + int'(v.d4)) / 2;
    a2 = (int'(v.d3) + a1) / 2;
    m2 = (a2 * int'(v.ca)) / 256;
    m1 = (mode == 1) ? (int'(v.d1) * int'(v.cc)) / 256 :
         (mode == 2) ? (int'(v.d1) * int'(v.cb)) / 256 : 0;
    sum = m1 + m2;
    if (mode == 0 || mode == 3) begin
      r.es = v.d1; r.ew = v.d1; r.eovf = 1'b0; r.ewm = 1'b0;
    end else begin
      r.eovf = (sum > 255);
      r.es = r.eovf ? 8'd255 : 8'(sum);
      r.ew = 8'(sum % 256);
      r.ewm = 1'b1;
    end
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.en = ($urandom_range(0, 7) != 0);
    v.wm = 2'($urandom_range(0, 3));
    v.d1 = 8'($urandom_range(0, 255)); v.d2 = 8'($urandom_range(0, 255));
    v.d3 = 8'($urandom_range(0, 255)); v.d4 = 8'($urandom_range(0, 255));
    v.ca = 9'($urandom_range(0, 511)); v.cb = 9'($urandom_range(0, 511));
    v.cc = 9'($urandom_range(0, 511));
    v.last = 1'($urandom_range(0, 1));
    return model(v);
  endfunction

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.ds = v.es; e.dw = v.ew; e.last = v.last; e.ovf = v.eovf; e.wm = v.ewm;
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] cinc(input logic [CNT_W-1:0] c);
    return (c == CNT_FULL) ? c : c + 1'b1;
  endfunction

  task automatic drive(input vec_t v);
    enable = v.en; wm_data = v.wm;
    data1 = v.d1; data2 = v.d2; data3 = v.d3; data4 = v.d4;
    coef_a = v.ca; coef_b = v.cb; coef_c = v.cc;
    in_last = v.last;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v);
    int n;
    drive(v);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_s) note_fail("accept_timeout");
    else sb.push_back(to_exp(v));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // Output monitor: scoreboard pop, hold-while-stalled, counter model.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("wm_count_s", wmc_s, m_wm);
      chk("wm_count_w", wmc_w, m_wm);
      chk("sat_count_s", satc_s, m_sat);
      chk("sat_count_w", satc_w, m_sat);
      if (prev_stall) begin
        chk("hold_data_s", data_s, prev_ds);
        chk("hold_data_w", data_w, prev_dw);
        chk("hold_last", last_s, prev_last);
      end
      prev_stall = out_valid_s && !out_ready;
      prev_ds = data_s; prev_dw = data_w; prev_last = last_s;
      if (out_valid_s && out_ready) begin
        if (sb.size() == 0) begin
          note_fail("unexpected_beat");
        end else begin
          e = sb.pop_front();
          chk("data_sat", data_s, e.ds);
          chk("data_wrap", data_w, e.dw);
          chk("out_last", last_s, e.last);
          chk("out_valid_w", out_valid_w, 1);
          if (!cnt_clr) begin
            if (e.wm) m_wm = cinc(m_wm);
            if (e.ovf) m_sat = cinc(m_sat);
          end
        end
      end
      if (cnt_clr) begin
        m_wm = '0;
        m_sat = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    vec_t v;
    int n;
    tbl[0] = mk(1, 2'b01, 100, 40, 70, 60, 64, 0, 230, 104, 104, 0, 1);
    tbl[1] = mk(1, 2'b10, 200, 255, 255, 255, 256, 384, 0, 255, 43, 1, 1);
    tbl[2] = mk(1, 2'b00, 77, 255, 255, 255, 256, 384, 230, 77, 77, 0, 0);
    tbl[3] = mk(1, 2'b11, 77, 255, 255, 255, 256, 384, 230, 77, 77, 0, 0);
    tbl[4] = mk(0, 2'b01, 77, 255, 255, 255, 256, 384, 230, 77, 77, 0, 0);
    tbl[5] = mk(1, 2'b01, 200, 10, 20, 30, 0, 100, 0, 0, 0, 0, 1);
    tbl[6] = mk(1, 2'b10, 90, 10, 40, 30, int'(COEF_ONE), int'(COEF_ONE), 0, 120, 120, 0, 1);
    tbl[7] = mk(1, 2'b01, 255, 0, 0, 0, 0, 0, 256, 255, 255, 0, 1);
    tbl[8] = mk(1, 2'b01, 255, 1, 1, 1, 256, 0, 256, 255, 0, 1, 1);
    tbl[9] = mk(1, 2'b10, 255, 255, 255, 255, 511, 511, 0, 255, 250, 1, 1);
    tbl[9].last = 1'b1;

    // Reset values
    #3;
    chk("rst_out_valid", out_valid_s, 0);
    chk("rst_data", data_s, 0);
    chk("rst_last", last_s, 0);
    chk("rst_wm_count", wmc_s, 0);
    chk("rst_sat_count", satc_s, 0);
    #9 rst_n = 1'b1;
    #1 chk("in_ready_pre_clk", in_ready_s, 0);
    @(posedge clk);
    #1 chk("in_ready_post_clk", in_ready_s, 1);

    // Latency: accepted at one edge, valid after the third edge
    drive(tbl[0]);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    sb.push_back(to_exp(tbl[0]));
    @(posedge clk);
    #1 chk("latency_2", out_valid_s, 0);
    @(posedge clk);
    #1 chk("latency_3", out_valid_s, 1);
    wait_idle();

    // Table vectors back to back
    for (int i = 0; i < 10; i++) send(tbl[i]);
    wait_idle();

    // Clear in the same cycle as a watermarked output handshake
    send(tbl[0]);
    n = 0;
    while (!out_valid_s && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid_s) note_fail("clr_wait_timeout");
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    chk("clr_wins_wm", wmc_s, 0);
    chk("clr_wins_sat", satc_s, 0);
    wait_idle();

    // Back-pressure: six beats, five-cycle stall mid-stream
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          v = rand_vec();
          v.last = (i == 5);
          send(v);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("in_ready_stalled", in_ready_s, 0);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_idle();

    // Random stream with random downstream readiness
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 30; i++) send(rand_vec());
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset with three beats in flight and the output stalled
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(tbl[1]);
    chk("pre_reset_valid", out_valid_s, 1);
    #1 rst_n = 1'b0;
    sb.delete();
    m_wm = '0;
    m_sat = '0;
    #1;
    chk("reset_valid_s", out_valid_s, 0);
    chk("reset_valid_w", out_valid_w, 0);
    chk("reset_wm_count", wmc_s, 0);
    chk("reset_sat_count", satc_w, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("rel_in_ready_pre", in_ready_s, 0);
    @(posedge clk);
    #1 chk("rel_in_ready_post", in_ready_s, 1);
    repeat (8) @(posedge clk);
    #1 chk("no_stale_beat", out_valid_s, 0);

    // Counter saturation at all-ones
    for (int i = 0; i < 17; i++) send(tbl[1]);
    wait_idle();
    @(posedge clk);
    #1;
    chk("wm_count_saturated", wmc_s, CNT_FULL);
    chk("sat_count_saturated", satc_s, CNT_FULL);
    send(tbl[0]);
    wait_idle();
    @(posedge clk);
    #1 chk("wm_count_holds", wmc_s, CNT_FULL);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
